// File: rtl/fp_add_sequencer.sv
// Control sequencer for the multi-cycle floating-point adder: Go/Busy/Done handshake,
// alignment, normalisation and rounding controls with bounded re-normalisation.
module fp_add_sequencer #(
    parameter int unsigned EXPBITS      = 8,
    parameter int unsigned MANTISSABITS = 23,
    parameter int unsigned MAXROUNDS    = 2,
    localparam int unsigned SHW         = $clog2(MANTISSABITS + 2)
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               go_i,
    input  logic               exp_set_i,
    input  logic [EXPBITS-1:0] exp_diff_i,
    input  logic               ffo_valid_i,
    input  logic [SHW-1:0]     ffo_index_i,
    input  logic               round_ovf_i,
    output logic               busy_o,
    output logic               done_o,
    output logic               err_round_o,
    output logic [2:0]         state_o,
    output logic               sel_exp_mux_o,
    output logic               sel_sr_mux_g_o,
    output logic               sel_sr_mux_l_o,
    output logic               shift_right_enable_o,
    output logic [SHW-1:0]     shift_right_amount_o,
    output logic               sre_en_c_o,
    output logic               sle_en_c_o,
    output logic               no_shift_c_o,
    output logic               incr_en_c_o,
    output logic               decr_en_c_o,
    output logic [SHW-1:0]     shift_amount_c_o,
    output logic               sel_exp_mux_r_o,
    output logic               sel_man_mux_r_o
);

    localparam int unsigned PW    = (MAXROUNDS < 1) ? 1 : $clog2(MAXROUNDS + 1);
    localparam int unsigned MAXSR = MANTISSABITS + 1;
    localparam int unsigned CW    = (EXPBITS > SHW) ? EXPBITS : SHW;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ALIGN = 3'd1;
    localparam logic [2:0] S_NORM  = 3'd2;
    localparam logic [2:0] S_ROUND = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0]         state_q, state_d;
    logic               exp_set_q, exp_set_d;
    logic [EXPBITS-1:0] exp_diff_q, exp_diff_d;
    logic [PW-1:0]      passes_q, passes_d;
    logic               err_q, err_d;

    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               sel_exp_mux_q, sel_exp_mux_d;
    logic               sel_sr_mux_l_q, sel_sr_mux_l_d;
    logic               sr_en_q, sr_en_d;
    logic [SHW-1:0]     sr_amt_q, sr_amt_d;
    logic               sel_r_q, sel_r_d;

    // State register plus registered state-derived outputs.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q        <= S_IDLE;
            exp_set_q      <= 1'b0;
            exp_diff_q     <= '0;
            passes_q       <= '0;
            err_q          <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            sel_exp_mux_q  <= 1'b0;
            sel_sr_mux_l_q <= 1'b0;
            sr_en_q        <= 1'b0;
            sr_amt_q       <= '0;
            sel_r_q        <= 1'b0;
        end else begin
            state_q        <= state_d;
            exp_set_q      <= exp_set_d;
            exp_diff_q     <= exp_diff_d;
            passes_q       <= passes_d;
            err_q          <= err_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
            sel_exp_mux_q  <= sel_exp_mux_d;
            sel_sr_mux_l_q <= sel_sr_mux_l_d;
            sr_en_q        <= sr_en_d;
            sr_amt_q       <= sr_amt_d;
            sel_r_q        <= sel_r_d;
        end
    end

    // Next state; normalisation controls follow the live leading-one inputs.
    always_comb begin
        state_d          = state_q;
        exp_set_d        = exp_set_q;
        exp_diff_d       = exp_diff_q;
        passes_d         = passes_q;
        err_d            = err_q;
        sre_en_c_o       = 1'b0;
        sle_en_c_o       = 1'b0;
        no_shift_c_o     = 1'b0;
        incr_en_c_o      = 1'b0;
        decr_en_c_o      = 1'b0;
        shift_amount_c_o = '0;

        case (state_q)
            S_IDLE: begin
                if (go_i) begin
                    state_d    = S_ALIGN;
                    exp_set_d  = exp_set_i;
                    exp_diff_d = exp_diff_i;
                    passes_d   = '0;
                    err_d      = 1'b0;
                end
            end
            S_ALIGN: state_d = S_NORM;
            S_NORM: begin
                if (!ffo_valid_i) begin
                    no_shift_c_o = 1'b1;
                    state_d      = S_DONE;
                end else if (ffo_index_i == SHW'(MANTISSABITS + 1)) begin
                    sre_en_c_o       = 1'b1;
                    incr_en_c_o      = 1'b1;
                    shift_amount_c_o = SHW'(1);
                    state_d          = S_ROUND;
                end else if (ffo_index_i == SHW'(MANTISSABITS)) begin
                    no_shift_c_o = 1'b1;
                    state_d      = S_ROUND;
                end else begin
                    sle_en_c_o       = 1'b1;
                    decr_en_c_o      = 1'b1;
                    shift_amount_c_o = SHW'(MANTISSABITS) - ffo_index_i;
                    state_d          = S_ROUND;
                end
            end
            S_ROUND: begin
                if (round_ovf_i && (passes_q < PW'(MAXROUNDS))) begin
                    passes_d = passes_q + PW'(1);
                    state_d  = S_NORM;
                end else begin
                    if (round_ovf_i) begin
                        err_d = 1'b1;
                    end
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Registered decode of the upcoming state; shift amount saturates at MANTISSABITS+1.
    always_comb begin
        busy_d         = (state_d != S_IDLE);
        done_d         = (state_d == S_DONE);
        sel_exp_mux_d  = (state_d == S_ALIGN) && exp_set_d;
        sel_sr_mux_l_d = (state_d == S_ALIGN) && !exp_set_d;
        sr_en_d        = (state_d == S_ALIGN) && (exp_diff_d != '0);
        sr_amt_d       = '0;
        if (state_d == S_ALIGN) begin
            if (CW'(exp_diff_d) > CW'(MAXSR)) begin
                sr_amt_d = SHW'(MAXSR);
            end else begin
                sr_amt_d = SHW'(exp_diff_d);
            end
        end
        sel_r_d = (state_d == S_ROUND);
    end

    assign state_o              = state_q;
    assign busy_o               = busy_q;
    assign done_o               = done_q;
    assign err_round_o          = err_q;
    assign sel_exp_mux_o        = sel_exp_mux_q;
    assign sel_sr_mux_g_o       = sel_exp_mux_q;
    assign sel_sr_mux_l_o       = sel_sr_mux_l_q;
    assign shift_right_enable_o = sr_en_q;
    assign shift_right_amount_o = sr_amt_q;
    assign sel_exp_mux_r_o      = sel_r_q;
    assign sel_man_mux_r_o      = sel_r_q;

endmodule

// File: tb/tb_fp_add_sequencer.sv
// Randomised bench for fp_add_sequencer: an operation-level model predicts every
// cycle's outputs from the operands and the FFO/overflow values fed to each pass.
module tb_fp_add_sequencer;

    localparam int unsigned EB  = 8;
    localparam int unsigned MB  = 23;
    localparam int unsigned MR  = 2;
    localparam int unsigned SHW = 5;

    logic           clk = 1'b0;
    logic           rst;
    logic           go, exp_set, ffo_valid, round_ovf;
    logic [EB-1:0]  exp_diff;
    logic [SHW-1:0] ffo_index;
    logic           busy, done, err_round;
    logic [2:0]     state;
    logic           sel_exp_mux, sel_sr_mux_g, sel_sr_mux_l, sr_en;
    logic [SHW-1:0] sr_amt;
    logic           sre_en, sle_en, no_shift, incr_en, decr_en;
    logic [SHW-1:0] shift_amt;
    logic           sel_exp_mux_r, sel_man_mux_r;

    always #5 clk = ~clk;

    fp_add_sequencer #(.EXPBITS(EB), .MANTISSABITS(MB), .MAXROUNDS(MR)) dut (
        .clk_i(clk), .rst_i(rst), .go_i(go), .exp_set_i(exp_set), .exp_diff_i(exp_diff),
        .ffo_valid_i(ffo_valid), .ffo_index_i(ffo_index), .round_ovf_i(round_ovf),
        .busy_o(busy), .done_o(done), .err_round_o(err_round), .state_o(state),
        .sel_exp_mux_o(sel_exp_mux), .sel_sr_mux_g_o(sel_sr_mux_g), .sel_sr_mux_l_o(sel_sr_mux_l),
        .shift_right_enable_o(sr_en), .shift_right_amount_o(sr_amt),
        .sre_en_c_o(sre_en), .sle_en_c_o(sle_en), .no_shift_c_o(no_shift),
        .incr_en_c_o(incr_en), .decr_en_c_o(decr_en), .shift_amount_c_o(shift_amt),
        .sel_exp_mux_r_o(sel_exp_mux_r), .sel_man_mux_r_o(sel_man_mux_r)
    );

    typedef struct packed {
        logic [2:0]     st;
        logic           busy, done, err, sem, smg, sml, sre_en;
        logic [SHW-1:0] sra;
        logic           sr, sl, ns, inc, dec;
        logic [SHW-1:0] sa;
        logic           semr, smmr;
    } obs_t;

    int   total = 0;
    int   bad   = 0;
    logic model_err = 1'b0;

    function automatic obs_t sample();
        obs_t o;
        o.st = state; o.busy = busy; o.done = done; o.err = err_round;
        o.sem = sel_exp_mux; o.smg = sel_sr_mux_g; o.sml = sel_sr_mux_l;
        o.sre_en = sr_en; o.sra = sr_amt;
        o.sr = sre_en; o.sl = sle_en; o.ns = no_shift; o.inc = incr_en; o.dec = decr_en;
        o.sa = shift_amt; o.semr = sel_exp_mux_r; o.smmr = sel_man_mux_r;
        return o;
    endfunction

    function automatic obs_t exp_align(input logic es, input logic [EB-1:0] ed);
        obs_t o = '0;
        o.st = 3'd1; o.busy = 1'b1;
        o.sem = es; o.smg = es; o.sml = !es;
        o.sre_en = (ed != 0);
        o.sra = (int'(ed) > MB + 1) ? SHW'(MB + 1) : SHW'(ed);
        return o;
    endfunction

    function automatic obs_t exp_norm(input logic v, input int idx);
        obs_t o = '0;
        o.st = 3'd2; o.busy = 1'b1;
        if (!v) o.ns = 1'b1;
        else if (idx == MB + 1) begin o.sr = 1'b1; o.inc = 1'b1; o.sa = SHW'(1); end
        else if (idx == MB) o.ns = 1'b1;
        else begin o.sl = 1'b1; o.dec = 1'b1; o.sa = SHW'(MB - idx); end
        return o;
    endfunction

    task automatic step_chk(input string nm, input obs_t e, output obs_t a);
        #1;
        a = sample();
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s t=%0t act=%h exp=%h", nm, $time, a, e);
        end
    endtask

    task automatic chk_val(input string nm, input int act, input int expv);
        total++;
        if (act != expv) begin
            bad++;
            $display("FAIL %s act=%0d exp=%0d", nm, act, expv);
        end
    endtask

    task automatic rand_misc();
        ffo_valid = 1'($urandom);
        ffo_index = SHW'($urandom_range(0, MB + 1));
        round_ovf = 1'($urandom);
    endtask

    // One operation from IDLE to DONE; lat is the cycle after Go where Done was seen.
    task automatic run_op(input logic es, input logic [EB-1:0] ed, input logic [2:0] fv,
                          input logic [14:0] fi, input logic [2:0] ov, input bit rst_round,
                          output int lat, output obs_t a_obs, output obs_t n_obs);
        obs_t e, a;
        int   cyc, k;
        bit   fin;
        lat = 0; n_obs = '0;
        @(negedge clk);
        go = 1'b1; exp_set = es; exp_diff = ed; rand_misc();
        e = '0; e.err = model_err;
        step_chk("idle_go", e, a);
        model_err = 1'b0;
        cyc = 1;
        @(negedge clk);
        go = 1'($urandom); exp_set = 1'($urandom); exp_diff = EB'($urandom); rand_misc();
        step_chk("align", exp_align(es, ed), a_obs);
        if (lat == 0 && a_obs.done) lat = cyc;
        k = 0; fin = 0;
        while (!fin) begin
            cyc++;
            @(negedge clk);
            go = 1'($urandom); round_ovf = 1'($urandom);
            ffo_valid = fv[k]; ffo_index = fi[k*5 +: 5];
            e = exp_norm(fv[k], int'(fi[k*5 +: 5])); e.err = model_err;
            step_chk("norm", e, a);
            if (k == 0) n_obs = a;
            if (lat == 0 && a.done) lat = cyc;
            if (!fv[k]) fin = 1;
            else begin
                cyc++;
                @(negedge clk);
                go = 1'($urandom); rand_misc(); round_ovf = ov[k];
                e = '0; e.st = 3'd3; e.busy = 1'b1; e.semr = 1'b1; e.smmr = 1'b1; e.err = model_err;
                step_chk("round", e, a);
                if (lat == 0 && a.done) lat = cyc;
                if (rst_round) begin
                    #2 rst = 1'b1;
                    model_err = 1'b0;
                    step_chk("rst_async", '0, a);
                    @(negedge clk);
                    rst = 1'b0; go = 1'b0;
                    for (int i = 0; i < 3; i++) begin
                        @(negedge clk);
                        step_chk("rst_idle", '0, a);
                    end
                    return;
                end
                if (ov[k] && k < MR) k++;
                else begin
                    if (ov[k]) model_err = 1'b1;
                    fin = 1;
                end
            end
        end
        cyc++;
        @(negedge clk);
        go = 1'($urandom); exp_set = 1'($urandom); exp_diff = EB'($urandom); rand_misc();
        e = '0; e.st = 3'd4; e.busy = 1'b1; e.done = 1'b1; e.err = model_err;
        step_chk("done", e, a);
        if (lat == 0 && a.done) lat = cyc;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        obs_t a, n, r;
        int   lat;
        logic [2:0]  fv, ov;
        logic [14:0] fi;
        rst = 1'b1; go = 1'b0; exp_set = 1'b0; exp_diff = '0;
        ffo_valid = 1'b0; ffo_index = '0; round_ovf = 1'b0;
        #12;
        step_chk("reset", '0, r);
        @(negedge clk);
        rst = 1'b0;

        run_op(1'b1, 8'd5, 3'b111, {5'd0, 5'd0, 5'd23}, 3'b000, 0, lat, a, n);
        chk_val("d1_lat", lat, 4);
        chk_val("d1_sra", int'(a.sra), 5);
        chk_val("d1_smg", int'(a.smg), 1);
        chk_val("d1_noshift", int'(n.ns), 1);

        run_op(1'b0, 8'd200, 3'b111, {5'd0, 5'd0, 5'd24}, 3'b000, 0, lat, a, n);
        chk_val("d2_sra", int'(a.sra), 24);
        chk_val("d2_sml", int'(a.sml), 1);
        chk_val("d2_sem", int'(a.sem), 0);
        chk_val("d2_sre_inc", int'({n.sr, n.inc}), 3);
        chk_val("d2_sa", int'(n.sa), 1);

        run_op(1'b1, 8'd0, 3'b111, {5'd0, 5'd0, 5'd10}, 3'b000, 0, lat, a, n);
        chk_val("d3_sle_dec", int'({n.sl, n.dec}), 3);
        chk_val("d3_sa", int'(n.sa), 13);
        chk_val("d3_sr_en", int'(a.sre_en), 0);

        run_op(1'b0, 8'd3, 3'b000, 15'd0, 3'b111, 0, lat, a, n);
        chk_val("d4_zero_lat", lat, 3);

        run_op(1'b1, 8'd1, 3'b111, {5'd23, 5'd23, 5'd23}, 3'b111, 0, lat, a, n);
        chk_val("d5_err_lat", lat, 8);
        chk_val("d5_err", int'(err_round), 1);

        run_op(1'b1, 8'd2, 3'b111, {5'd0, 5'd0, 5'd23}, 3'b000, 0, lat, a, n);
        chk_val("d6_err_cleared", int'(a.err), 0);

        run_op(1'b0, 8'd7, 3'b111, {5'd0, 5'd0, 5'd24}, 3'b001, 1, lat, a, n);
        chk_val("d7_no_done", lat, 0);

        for (int op = 0; op < 300; op++) begin
            for (int k = 0; k < 3; k++) begin
                int r2;
                fv[k] = ($urandom_range(0, 99) < 85);
                ov[k] = ($urandom_range(0, 99) < 40);
                r2 = int'($urandom_range(0, 3));
                fi[k*5 +: 5] = (r2 == 0) ? 5'd24 : (r2 == 1) ? 5'd23 : 5'($urandom_range(0, 22));
            end
            run_op(1'($urandom), EB'($urandom), fv, fi, ov, 0, lat, a, n);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
